fpu_addsub_param: RTL and testbench

Parametrised sign-magnitude floating-point adder/subtractor. It is the next generation of the tinyZuse FPU add/sub path. It adds over the current unit:

- generic exponent and mantissa widths
- explicit operand and result signs
- zero operands
- a start/done handshake
- overflow and underflow flags

Alignment and normalisation are iterative, one bit per clock, so area stays small enough for the Tiny Tapeout tile. It sits between the register file and the result write-back mux.

---
 rtl/fpu_addsub_param.sv | 235 +++++++++++++++++++++++
 tb/tb_fpu_addsub_param.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fpu_addsub_param.sv
// fpu_addsub_param
//   Sign-magnitude floating-point adder/subtractor with parametrised
//   exponent/mantissa widths. Alignment and normalisation run one bit per
//   clock. Value = (-1)^s * m * 2^(e-(MAN_W-1)); m[MAN_W-1] is the explicit
//   leading one, m == 0 encodes zero.
//
// Ports
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset
//   start, sub       operation request (sampled in IDLE), 1 = a-b
//   a_s/a_e/a_m      operand a sign / exponent (two's complement) / mantissa
//   b_s/b_e/b_m      operand b sign / exponent / mantissa
//   res_s/res_e/res_m  result, held until the next done
//   busy             operation in flight
//   done             one-cycle pulse when results and flags update
//   ovf/unf          exponent overflow / underflow of the last result
module fpu_addsub_param #(
    parameter int EXP_W = 7,
    parameter int MAN_W = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic             a_s,
    input  logic [EXP_W-1:0] a_e,
    input  logic [MAN_W-1:0] a_m,
    input  logic             b_s,
    input  logic [EXP_W-1:0] b_e,
    input  logic [MAN_W-1:0] b_m,
    output logic             res_s,
    output logic [EXP_W-1:0] res_e,
    output logic [MAN_W-1:0] res_m,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             unf
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int                     FLUSH_D = MAN_W + 2;
    localparam logic signed [EXP_W:0]  EXP_MAX = (EXP_W+1)'(2**(EXP_W-1) - 1);
    localparam logic signed [EXP_W:0]  EXP_MIN = (EXP_W+1)'(-(2**(EXP_W-1)));
    localparam logic signed [EXP_W:0]  EXP_ONE = (EXP_W+1)'(1);
    localparam logic        [EXP_W:0]  D_ONE   = (EXP_W+1)'(1);

    typedef struct packed {
        logic             ovf;
        logic             unf;
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
    } res_t;

    // Final packing: zero canonicalisation plus saturation on overflow and
    // flush-to-+0 on underflow.
    function automatic res_t range_check(input logic zero, input logic s,
                                         input logic signed [EXP_W:0] e,
                                         input logic [MAN_W-1:0] m);
        res_t r;
        r = '0;
        if (zero) begin
            r = '0;
        end else if (e > EXP_MAX) begin
            r.ovf = 1'b1;
            r.s   = s;
            r.e   = EXP_MAX[EXP_W-1:0];
            r.m   = '1;
        end else if (e < EXP_MIN) begin
            r.unf = 1'b1;
        end else begin
            r.s = s;
            r.e = e[EXP_W-1:0];
            r.m = m;
        end
        return r;
    endfunction

    // control / output registers (reset)
    logic [2:0]       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    res_t             res_q, res_d;

    // datapath registers (no reset)
    logic             eff_sub_q, eff_sub_d;
    logic             sgn_q, sgn_d;
    logic             zero_q, zero_d;
    logic [MAN_W-1:0] big_m_q, big_m_d;
    logic [MAN_W-1:0] small_m_q, small_m_d;
    logic [MAN_W:0]   acc_q, acc_d;
    logic signed [EXP_W:0] exp_q, exp_d;
    logic [EXP_W:0]   d_q, d_d;

    logic signed [EXP_W:0] a_ext, b_ext, diff;
    logic             b_eff_s, a_zero, b_zero, a_big;
    logic [MAN_W:0]   sum;

    assign a_ext   = {a_e[EXP_W-1], a_e};
    assign b_ext   = {b_e[EXP_W-1], b_e};
    assign b_eff_s = b_s ^ sub;
    assign a_zero  = (a_m == '0);
    assign b_zero  = (b_m == '0);
    // Ties go to a; an exact tie under subtraction yields a zero sum anyway.
    assign a_big   = (a_ext > b_ext) || ((a_ext == b_ext) && (a_m >= b_m));
    assign diff    = a_big ? (a_ext - b_ext) : (b_ext - a_ext);
    // Magnitude ordering guarantees big >= small, so the difference never wraps.
    assign sum     = eff_sub_q ? ({1'b0, big_m_q} - {1'b0, small_m_q})
                               : ({1'b0, big_m_q} + {1'b0, small_m_q});

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        res_d     = res_q;
        eff_sub_d = eff_sub_q;
        sgn_d     = sgn_q;
        zero_d    = zero_q;
        big_m_d   = big_m_q;
        small_m_d = small_m_q;
        acc_d     = acc_q;
        exp_d     = exp_q;
        d_d       = d_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (a_zero || b_zero) begin
                        // Pass the nonzero operand straight through.
                        zero_d  = a_zero && b_zero;
                        sgn_d   = a_zero ? b_eff_s : a_s;
                        exp_d   = a_zero ? b_ext : a_ext;
                        acc_d   = a_zero ? {1'b0, b_m} : {1'b0, a_m};
                        state_d = S_DONE;
                    end else begin
                        zero_d    = 1'b0;
                        eff_sub_d = a_s ^ b_eff_s;
                        sgn_d     = a_big ? a_s : b_eff_s;
                        big_m_d   = a_big ? a_m : b_m;
                        small_m_d = a_big ? b_m : a_m;
                        exp_d     = a_big ? a_ext : b_ext;
                        d_d       = diff;
                        state_d   = (diff != '0) ? S_ALIGN : S_ADD;
                    end
                end
            end
            S_ALIGN: begin
                // A shift distance beyond the mantissa plus guard room clears
                // small in one go rather than walking it out bit by bit.
                if (32'(d_q) >= 32'(FLUSH_D)) begin
                    small_m_d = '0;
                    d_d       = '0;
                    state_d   = S_ADD;
                end else begin
                    small_m_d = small_m_q >> 1;
                    d_d       = d_q - D_ONE;
                    if (d_q == D_ONE) state_d = S_ADD;
                end
            end
            S_ADD: begin
                acc_d = sum;
                if (sum == '0) begin
                    zero_d  = 1'b1;
                    state_d = S_DONE;
                end else if (sum[MAN_W] || !sum[MAN_W-1]) begin
                    state_d = S_NORM;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_NORM: begin
                if (acc_q[MAN_W]) begin
                    acc_d   = acc_q >> 1;
                    exp_d   = exp_q + EXP_ONE;
                    state_d = S_DONE;
                end else begin
                    acc_d = acc_q << 1;
                    exp_d = exp_q - EXP_ONE;
                    // The bit about to become the leading one ends the walk.
                    if (acc_q[MAN_W-2]) state_d = S_DONE;
                end
            end
            S_DONE: begin
                res_d   = range_check(zero_q, sgn_q, exp_q, acc_q[MAN_W-1:0]);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    always_ff @(posedge clk) begin
        eff_sub_q <= eff_sub_d;
        sgn_q     <= sgn_d;
        zero_q    <= zero_d;
        big_m_q   <= big_m_d;
        small_m_q <= small_m_d;
        acc_q     <= acc_d;
        exp_q     <= exp_d;
        d_q       <= d_d;
    end

    assign res_s = res_q.s;
    assign res_e = res_q.e;
    assign res_m = res_q.m;
    assign ovf   = res_q.ovf;
    assign unf   = res_q.unf;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_fpu_addsub_param.sv
// Directed testbench for fpu_addsub_param (EXP_W=7, MAN_W=15).
module tb_fpu_addsub_param;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        a_s = 1'b0, b_s = 1'b0;
    logic [6:0]  a_e = '0, b_e = '0;
    logic [14:0] a_m = '0, b_m = '0;
    logic        res_s;
    logic [6:0]  res_e;
    logic [14:0] res_m;
    logic        busy, done, ovf, unf;

    int n_cmp = 0;
    int n_err = 0;

    fpu_addsub_param #(.EXP_W(7), .MAN_W(15)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .sub(sub),
        .a_s(a_s), .a_e(a_e), .a_m(a_m),
        .b_s(b_s), .b_e(b_e), .b_m(b_m),
        .res_s(res_s), .res_e(res_e), .res_m(res_m),
        .busy(busy), .done(done), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic as, input logic [6:0] ae, input logic [14:0] am,
                         input logic bs, input logic [6:0] be, input logic [14:0] bm,
                         input logic sb);
        @(negedge clk);
        a_s = as; a_e = ae; a_m = am;
        b_s = bs; b_e = be; b_m = bm;
        sub = sb; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_op(input string tag,
                          input logic as, input logic [6:0] ae, input logic [14:0] am,
                          input logic bs, input logic [6:0] be, input logic [14:0] bm,
                          input logic sb, input int lat,
                          input logic es, input logic [6:0] ee, input logic [14:0] em,
                          input logic eo, input logic eu);
        int k;
        drive(as, ae, am, bs, be, bm, sb);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        k = 0;
        while (k < 64) begin
            @(posedge clk);
            #1;
            k++;
            if (done) break;
        end
        check({tag, "_lat"}, k, lat);
        check({tag, "_s"}, 32'(res_s), 32'(es));
        check({tag, "_e"}, 32'(res_e), 32'(ee));
        check({tag, "_m"}, 32'(res_m), 32'(em));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        check({tag, "_unf"}, 32'(unf), 32'(eu));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        #2;
        check("rst_res_m", 32'(res_m), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        //        tag        as  ae     am        bs  be     bm        sub lat es  ee     em        o  u
        run_op("one_plus_one", 0, 7'h00, 15'h4000, 0, 7'h00, 15'h4000, 0, 3, 0, 7'h01, 15'h4000, 0, 0);
        run_op("three_m_one",  0, 7'h01, 15'h6000, 0, 7'h00, 15'h4000, 1, 3, 0, 7'h01, 15'h4000, 0, 0);
        run_op("one_m_075",    0, 7'h00, 15'h4000, 0, 7'h7F, 15'h6000, 1, 5, 0, 7'h7E, 15'h4000, 0, 0);
        run_op("x_m_x",        0, 7'h05, 15'h5000, 0, 7'h05, 15'h5000, 1, 2, 0, 7'h00, 15'h0000, 0, 0);
        run_op("zero_p_m2",    0, 7'h00, 15'h0000, 1, 7'h01, 15'h4000, 0, 1, 1, 7'h01, 15'h4000, 0, 0);
        run_op("flush",        0, 7'h00, 15'h4000, 0, 7'h6C, 15'h4000, 0, 3, 0, 7'h00, 15'h4000, 0, 0);
        run_op("max_p_max",    0, 7'h3F, 15'h4000, 0, 7'h3F, 15'h4000, 0, 3, 0, 7'h3F, 15'h7FFF, 1, 0);
        run_op("underflow",    0, 7'h40, 15'h6000, 0, 7'h40, 15'h4000, 1, 3, 0, 7'h00, 15'h0000, 0, 1);
        // Negative sign follows big: -3.0 + 1.0 = -2.0
        run_op("neg_big",      1, 7'h01, 15'h6000, 0, 7'h00, 15'h4000, 0, 3, 1, 7'h01, 15'h4000, 0, 0);
        // Leave a nonzero result in place before the mid-operation reset.
        run_op("pre_reset",    0, 7'h00, 15'h4000, 0, 7'h7F, 15'h6000, 1, 5, 0, 7'h7E, 15'h4000, 0, 0);

        // Reset while in NORM (1.0 - 0.75 is in NORM after edges 3 and 4).
        drive(0, 7'h00, 15'h4000, 0, 7'h7F, 15'h6000, 1);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_res_e", 32'(res_e), 32'd0);
        check("mid_rst_res_m", 32'(res_m), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("mid_rst_no_done", seen, 0);

        run_op("post_reset",   0, 7'h00, 15'h4000, 0, 7'h00, 15'h4000, 0, 3, 0, 7'h01, 15'h4000, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
